// File: rtl/calc_pkg.sv
// Shared definitions for the calc datapath: window FSM states, default
// widths and the accumulate-with-range-check helper used by the MAC.
package calc_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int WEIGHT_W_DEF = 8;
   localparam int SUM_W_DEF    = 21;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      ROW_WAIT,
      OUT
   } state_t;

   typedef struct packed {
      logic        ovf;
      logic [63:0] val;
   } add_res_t;

   // Adds two already-extended operands and checks the exact sum against the
   // sum_w range (signed or unsigned). With sat set the sum is clamped,
   // otherwise the caller keeps the low sum_w bits, which is the wrap result.
   function automatic add_res_t sat_add(input longint a, input longint b,
                                        input bit is_signed, input int sum_w,
                                        input bit sat);
      longint   s, lo, hi;
      add_res_t r;
      s = a + b;
      if (is_signed) begin
         lo = -(longint'(1) <<< (sum_w - 1));
         hi = (longint'(1) <<< (sum_w - 1)) - 1;
      end else begin
         lo = 0;
         hi = (longint'(1) <<< sum_w) - 1;
      end
      r.ovf = (s < lo) || (s > hi);
      if (sat && (s < lo)) s = lo;
      else if (sat && (s > hi)) s = hi;
      r.val = 64'(s);
      return r;
   endfunction

endpackage

// File: rtl/conv_dot_mac.sv
// Single-tap MAC step: extends one activation and one weight, multiplies,
// and adds the product to the running accumulator with overflow detection.
module conv_dot_mac
   import calc_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WEIGHT_W = WEIGHT_W_DEF,
   parameter int SUM_W    = SUM_W_DEF,
   parameter int SIGNED   = 0,
   parameter int SAT      = 0
) (
   input  logic [SUM_W-1:0]    acc,
   input  logic [DATA_W-1:0]   data,
   input  logic [WEIGHT_W-1:0] weight,
   output logic [SUM_W-1:0]    next_acc,
   output logic                ovf_step
);

   longint   acc_v;
   longint   prod_v;
   add_res_t add_r;
   logic     unused_hi;

   // Bring accumulator and operands into a wide signed domain so the add is exact.
   always_comb begin
      acc_v  = 0;
      prod_v = 0;
      if (SIGNED != 0) begin
         acc_v  = longint'($signed(acc));
         prod_v = longint'($signed(data)) * longint'($signed(weight));
      end else begin
         acc_v  = longint'(acc);
         prod_v = longint'(data) * longint'(weight);
      end
   end

   assign add_r     = sat_add(acc_v, prod_v, SIGNED != 0, SUM_W, SAT != 0);
   assign next_acc  = add_r.val[SUM_W-1:0];
   assign ovf_step  = add_r.ovf;
   assign unused_hi = ^add_r.val[63:SUM_W];

endmodule

// File: rtl/conv_window_dot_seq.sv
// KxKxNCH convolution window dot product with one serial MAC. Rows arrive
// over a valid/ready handshake; the result is held under out_valid/out_ready.
module conv_window_dot_seq
   import calc_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WEIGHT_W = WEIGHT_W_DEF,
   parameter int KSIZE    = 3,
   parameter int NCH      = 3,
   parameter int SUM_W    = SUM_W_DEF,
   parameter int SIGNED   = 0,
   parameter int SAT      = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           acc_keep,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NCH*DATA_W-1:0]          in_data,
   input  logic [KSIZE*NCH*WEIGHT_W-1:0]  weights,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [SUM_W-1:0]               out_dot,
   output logic                           out_ovf
);

   localparam int TAPS = KSIZE * NCH;
   localparam int RW   = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int LW   = (NCH > 1) ? $clog2(NCH) : 1;

   state_t                     state, next_state;
   logic [NCH*DATA_W-1:0]      row_reg;
   logic [TAPS*WEIGHT_W-1:0]   kern;
   logic [SUM_W-1:0]           acc, next_acc;
   logic                       ovf, ovf_step;
   logic [RW-1:0]              row;
   logic [LW-1:0]              lane;
   logic                       accept, last_lane, last_row;
   logic [DATA_W-1:0]          cur_data;
   logic [WEIGHT_W-1:0]        cur_weight;

   assign last_lane  = (lane == LW'(NCH - 1));
   assign last_row   = (row == RW'(KSIZE - 1));
   assign accept     = in_valid & in_ready;
   assign cur_data   = row_reg[int'(lane)*DATA_W +: DATA_W];
   assign cur_weight = kern[(int'(row)*NCH + int'(lane))*WEIGHT_W +: WEIGHT_W];

   conv_dot_mac #(
      .DATA_W   (DATA_W),
      .WEIGHT_W (WEIGHT_W),
      .SUM_W    (SUM_W),
      .SIGNED   (SIGNED),
      .SAT      (SAT)
   ) u_mac (
      .acc      (acc),
      .data     (cur_data),
      .weight   (cur_weight),
      .next_acc (next_acc),
      .ovf_step (ovf_step)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state and handshake outputs; clear forces IDLE and masks both handshakes.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE, ROW_WAIT: begin
            in_ready = 1'b1;
            if (in_valid) next_state = MAC;
         end
         MAC: begin
            if (last_lane) next_state = last_row ? OUT : ROW_WAIT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (clear) begin
         next_state = IDLE;
         in_ready   = 1'b0;
         out_valid  = 1'b0;
      end
   end

   // Row/kernel capture, lane-serial accumulation and result load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_reg <= '0;
         kern    <= '0;
         acc     <= '0;
         ovf     <= 1'b0;
         row     <= '0;
         lane    <= '0;
         out_dot <= '0;
         out_ovf <= 1'b0;
      end else if (clear) begin
         acc  <= '0;
         ovf  <= 1'b0;
         row  <= '0;
         lane <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  row_reg <= in_data;
                  kern    <= weights;
                  if (!acc_keep) begin
                     acc <= '0;
                     ovf <= 1'b0;
                  end
                  row  <= '0;
                  lane <= '0;
               end
            end
            ROW_WAIT: begin
               if (accept) begin
                  row_reg <= in_data;
                  row     <= row + RW'(1);
                  lane    <= '0;
               end
            end
            MAC: begin
               acc  <= next_acc;
               ovf  <= ovf | ovf_step;
               lane <= last_lane ? '0 : lane + LW'(1);
               if (last_lane && last_row) begin
                  out_dot <= next_acc;
                  out_ovf <= ovf | ovf_step;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_dot_seq.sv
// Bench for conv_window_dot_seq: four configurations share one stimulus
// stream; a window-level model predicts handshakes and results every cycle.
module tb_conv_window_dot_seq;

   localparam int K    = 3;
   localparam int N    = 3;
   localparam int TAPS = K * N;
   localparam int NDUT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic              acc_keep = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b1;
   logic [N*8-1:0]    in_data = '0;
   logic [TAPS*8-1:0] weights = '0;

   logic [NDUT-1:0]   in_ready_w, out_valid_w, out_ovf_w;
   logic [31:0]       dot_w [NDUT];

   // config g: 0 unsigned/21/wrap, 1 signed/21/wrap, 2 signed/16/sat, 3 signed/16/wrap
   int cfg_sg [NDUT] = '{0, 1, 1, 1};
   int cfg_sw [NDUT] = '{21, 21, 16, 16};
   int cfg_st [NDUT] = '{0, 0, 1, 0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int SG = (g > 0) ? 1 : 0;
      localparam int SW = (g >= 2) ? 16 : 21;
      localparam int ST = (g == 2) ? 1 : 0;
      logic [SW-1:0] dot;
      conv_window_dot_seq #(
         .DATA_W(8), .WEIGHT_W(8), .KSIZE(K), .NCH(N),
         .SUM_W(SW), .SIGNED(SG), .SAT(ST)
      ) u_dut (
         .clk(clk), .rst(rst), .clear(clear), .acc_keep(acc_keep),
         .in_valid(in_valid), .in_ready(in_ready_w[g]), .in_data(in_data),
         .weights(weights), .out_valid(out_valid_w[g]), .out_ready(out_ready),
         .out_dot(dot), .out_ovf(out_ovf_w[g])
      );
      assign dot_w[g] = 32'(dot);
   end

   // ---------------- model ----------------
   typedef struct {int win; int g; int dot; int ovf; int lat;} lit_t;
   lit_t   lit_tab[$];
   int     rst_done = 0;

   longint m_acc [NDUT], pend_dot [NDUT], held_dot [NDUT];
   logic   m_ovf [NDUT], pend_ovf [NDUT], held_ovf [NDUT];
   logic [7:0] m_kern [TAPS];
   int     rows_in = 0, ready_at = 0, out_at = 0, cyc = 0, start_cyc = 0;
   int     pend_id = 0, chk_id = 0, rst_seen = 0;
   bit     pending = 0;
   int     n_vec = 0, n_err = 0;

   function automatic longint ext8(input logic [7:0] v, input int g);
      return (cfg_sg[g] != 0) ? longint'($signed(v)) : longint'(v);
   endfunction

   function automatic longint mask(input int g);
      return (longint'(1) <<< cfg_sw[g]) - 1;
   endfunction

   function automatic longint model_add(input int g, input longint a, input longint p,
                                        output logic o);
      longint s, lo, hi, span;
      span = longint'(1) <<< cfg_sw[g];
      lo   = (cfg_sg[g] != 0) ? -(span / 2) : 0;
      hi   = lo + span - 1;
      s    = a + p;
      o    = (s < lo) || (s > hi);
      if (cfg_st[g] != 0) begin
         if (s < lo) s = lo;
         if (s > hi) s = hi;
      end else begin
         while (s > hi) s -= span;
         while (s < lo) s += span;
      end
      return s;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Compare outputs against the model mid-cycle, then advance the model
   // with the inputs the next rising edge will sample.
   always @(negedge clk) begin
      bit   er, ev;
      logic o;
      longint p;
      if (rst) begin
         pending  = 0;
         rows_in  = 0;
         ready_at = 0;
         for (int g = 0; g < NDUT; g++) begin
            m_acc[g] = 0; m_ovf[g] = 0; held_dot[g] = 0; held_ovf[g] = 0;
         end
      end else begin
         er = !clear && !pending && (cyc >= ready_at);
         ev = !clear && pending && (cyc >= out_at);
         if (pending && (cyc >= out_at))
            for (int g = 0; g < NDUT; g++) begin
               held_dot[g] = pend_dot[g]; held_ovf[g] = pend_ovf[g];
            end
         for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("in_ready[%0d]", g), longint'(in_ready_w[g]), longint'(er));
            chk($sformatf("out_valid[%0d]", g), longint'(out_valid_w[g]), longint'(ev));
            chk($sformatf("out_dot[%0d]", g), longint'(dot_w[g]), held_dot[g] & mask(g));
            chk($sformatf("out_ovf[%0d]", g), longint'(out_ovf_w[g]), longint'(held_ovf[g]));
         end
         if (rst_done != rst_seen) begin
            rst_seen = rst_done;
            for (int g = 0; g < NDUT; g++) begin
               chk($sformatf("post_rst_dot[%0d]", g), longint'(dot_w[g]), 0);
               chk($sformatf("post_rst_ready[%0d]", g), longint'(in_ready_w[g]), 1);
               chk($sformatf("post_rst_valid[%0d]", g), longint'(out_valid_w[g]), 0);
            end
         end
         if (ev && (pend_id != chk_id)) begin
            chk_id = pend_id;
            foreach (lit_tab[i]) if (lit_tab[i].win == pend_id) begin
               chk($sformatf("lit_dot w%0d[%0d]", pend_id, lit_tab[i].g),
                   longint'(dot_w[lit_tab[i].g]), longint'(lit_tab[i].dot));
               chk($sformatf("lit_model w%0d[%0d]", pend_id, lit_tab[i].g),
                   pend_dot[lit_tab[i].g] & mask(lit_tab[i].g), longint'(lit_tab[i].dot));
               chk($sformatf("lit_ovf w%0d[%0d]", pend_id, lit_tab[i].g),
                   longint'(out_ovf_w[lit_tab[i].g]), longint'(lit_tab[i].ovf));
               if (lit_tab[i].lat >= 0)
                  chk($sformatf("latency w%0d", pend_id), longint'(cyc - start_cyc),
                      longint'(lit_tab[i].lat));
            end
         end
         // end-of-cycle transition
         if (clear) begin
            pending  = 0;
            rows_in  = 0;
            ready_at = cyc + 1;
            for (int g = 0; g < NDUT; g++) begin m_acc[g] = 0; m_ovf[g] = 0; end
         end else if (in_valid && er) begin
            if (rows_in == 0) begin
               start_cyc = cyc;
               for (int t = 0; t < TAPS; t++) m_kern[t] = weights[t*8 +: 8];
               if (!acc_keep)
                  for (int g = 0; g < NDUT; g++) begin m_acc[g] = 0; m_ovf[g] = 0; end
            end
            for (int g = 0; g < NDUT; g++)
               for (int l = 0; l < N; l++) begin
                  p = ext8(in_data[l*8 +: 8], g) * ext8(m_kern[rows_in*N + l], g);
                  m_acc[g] = model_add(g, m_acc[g], p, o);
                  m_ovf[g] = m_ovf[g] | o;
               end
            rows_in++;
            if (rows_in == K) begin
               rows_in = 0;
               pending = 1;
               pend_id++;
               out_at  = cyc + N + 1;
               for (int g = 0; g < NDUT; g++) begin
                  pend_dot[g] = m_acc[g]; pend_ovf[g] = m_ovf[g];
               end
            end else begin
               ready_at = cyc + N + 1;
            end
         end else if (ev && out_ready) begin
            pending  = 0;
            ready_at = cyc + 1;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   function automatic logic [23:0] row3(input int a, input int b, input int c);
      return {8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input int win, input int g, input int dot, input int ovf, input int lat);
      lit_t e;
      e.win = win; e.g = g; e.dot = dot; e.ovf = ovf; e.lat = lat;
      lit_tab.push_back(e);
   endtask

   task automatic lit_all(input int win, input int dot);
      for (int g = 0; g < NDUT; g++) lit(win, g, dot, 0, -1);
   endtask

   task automatic send_row(input logic [23:0] d, input logic [71:0] w, input logic keep);
      int n;
      n = 0;
      in_data = d; weights = w; acc_keep = keep; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready_w[0]) break;
         n++;
         if (n > 50) begin
            $display("FAIL send_row: in_ready did not rise within 50 cycles");
            $fatal(1);
         end
      end
      tick();
      in_valid = 1'b0;
      in_data  = 24'($urandom);
      weights  = 72'({$urandom, $urandom, $urandom});
      acc_keep = 1'($urandom);
   endtask

   task automatic window(input logic [23:0] d0, input logic [23:0] d1, input logic [23:0] d2,
                         input logic [71:0] w, input logic keep);
      send_row(d0, w, keep);
      send_row(d1, w, 1'b0);
      send_row(d2, w, 1'b0);
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (out_valid_w[0] && out_ready) break;
         n++;
         if (n > 100) begin
            $display("FAIL wait_out: no result handshake within 100 cycles");
            $fatal(1);
         end
      end
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic [23:0] ones, m128;
      logic [71:0] w19;
      int n;
      ones = row3(1, 1, 1);
      m128 = row3(128, 128, 128);
      w19  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rst_done++;
      tick();

      // window 1: rows 1..9, unit kernel, back-to-back rows
      lit(1, 0, 45, 0, 12);
      for (int g = 1; g < NDUT; g++) lit(1, g, 45, 0, -1);
      window(row3(1, 2, 3), row3(4, 5, 6), row3(7, 8, 9), {9{8'd1}}, 1'b0);
      wait_out();

      // window 2: 0x80 everywhere (unsigned 128, signed -128)
      lit(2, 0, 147456, 0, -1);
      lit(2, 1, 147456, 0, -1);
      lit(2, 2, 32767, 1, -1);
      lit(2, 3, 16384, 1, -1);
      window(m128, m128, m128, {9{8'h80}}, 1'b0);
      wait_out();

      // window 3: result held under backpressure
      out_ready = 1'b0;
      lit_all(3, 18);
      window(ones, ones, ones, {9{8'd2}}, 1'b0);
      n = 0;
      forever begin
         @(negedge clk);
         if (out_valid_w[0]) break;
         n++;
         if (n > 50) begin
            $display("FAIL backpressure: out_valid did not rise");
            $fatal(1);
         end
      end
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_out();

      // window 4 keeps the accumulator, window 5 does not
      lit_all(4, 36);
      window(ones, ones, ones, {9{8'd2}}, 1'b1);
      wait_out();
      lit_all(5, 18);
      window(ones, ones, ones, {9{8'd2}}, 1'b0);
      wait_out();

      // abort during MAC of row 1, then a clean window
      send_row(ones, {9{8'd1}}, 1'b0);
      send_row(ones, {9{8'd1}}, 1'b0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      lit_all(6, 9);
      window(ones, ones, ones, {9{8'd1}}, 1'b0);
      wait_out();

      // kernel latched on first row; later rows present different weights
      lit_all(7, 285);
      send_row(row3(1, 2, 3), w19, 1'b0);
      send_row(row3(4, 5, 6), {9{8'hFF}}, 1'b0);
      send_row(row3(7, 8, 9), {9{8'hFF}}, 1'b0);
      wait_out();

      // async reset in the middle of a window
      send_row(ones, {9{8'd3}}, 1'b0);
      send_row(ones, {9{8'd3}}, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      rst_done++;
      tick();

      // random traffic
      repeat (3000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 24'($urandom);
         weights   = 72'({$urandom, $urandom, $urandom});
         acc_keep  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         clear     = ($urandom_range(0, 49) == 0);
         rst       = ($urandom_range(0, 499) == 0);
         tick();
      end
      in_valid = 1'b0; clear = 1'b0; rst = 1'b0; out_ready = 1'b1;
      repeat (20) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv_window_dot_seq.md
Name: conv_window_dot_seq

Overview:
- Parametrised successor to the fixed 3x3 cnt-decoded inner-dot connector.
- Computes one K×K×NCH convolution window dot product with a single serial MAC. Window rows are fed through a valid/ready handshake instead of global-counter decode.
- Adds signed/unsigned mode, kernel latching, cross-call accumulation (acc_keep), optional saturation with an overflow flag, and output backpressure.
- Sits between the line-buffer row reader and the activation/requant stage in the calc datapath.

Parameters:
- DATA_W, 8, activation lane width.
- WEIGHT_W, 8, weight width.
- KSIZE, 3, kernel rows per window (≥1).
- NCH, 3, lanes per row (≥1). TAPS = KSIZE*NCH is derived, not overridable.
- SUM_W, 21, accumulator and result width.
- SIGNED, 0, 1 = data, weights and accumulator are two's complement; 0 = unsigned.
- SAT, 0, 1 = saturate accumulation to the SUM_W range; 0 = wrap modulo 2^SUM_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous soft clear; aborts any operation.
- acc_keep  in  1  sampled with the first row; 1 = do not zero the accumulator.
- in_valid  in  1  row data valid.
- in_ready  out  1  block can accept a row.
- in_data  in  NCH*DATA_W  row lanes; lane i at bits [i*DATA_W +: DATA_W].
- weights  in  TAPS*WEIGHT_W  kernel; tap r*NCH+i at bits [(r*NCH+i)*WEIGHT_W +: WEIGHT_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_dot  out  SUM_W  window result (registered).
- out_ovf  out  1  overflow/saturation occurred during this window (registered).

Behaviour:
- States: IDLE, MAC, ROW_WAIT, OUT.
- Reset values (async rst): state IDLE; out_dot 0; out_ovf 0; out_valid 0; accumulator 0; row 0; lane 0.
- in_ready = 1 in IDLE and ROW_WAIT only; 0 otherwise, including the clear cycle.
- IDLE, on accept (in_valid & in_ready):
  - Latch in_data into the row register and weights into the kernel register.
  - Zero the accumulator and ovf unless acc_keep=1; with acc_keep=1 both are retained.
  - row←0, lane←0, go to MAC.
  - weights are sampled only here and may change afterwards.
- ROW_WAIT, on accept: latch in_data, row←row+1, lane←0, go to MAC. acc_keep is ignored.
- MAC: one lane per cycle: acc ← acc + ext(row_reg[lane]) * ext(kern[row*NCH+lane]).
  - Operands are zero- or sign-extended per SIGNED; the product is extended to SUM_W before the add.
  - Overflow on any add sets ovf (sticky per window).
  - SAT=1: clamp to [-2^(SUM_W-1), 2^(SUM_W-1)-1] if signed, or [0, 2^SUM_W-1] if unsigned.
  - SAT=0: wrap; ovf is still reported.
  - After lane NCH-1: go to ROW_WAIT if row < KSIZE-1; otherwise load out_dot←final acc and out_ovf←ovf, and go to OUT.
- OUT: out_valid=1. out_dot and out_ovf stay stable until out_valid & out_ready, then go to IDLE. out_dot/out_ovf hold their values in IDLE.
- Latency:
  - Row accepted at cycle t → in_ready high again at t+NCH+1.
  - Last row accepted at L → out_valid at L+NCH+1.
  - 3x3 with rows back-to-back: accepts at 0, 4, 8; out_valid at 12.
  - Minimum window period is KSIZE*(NCH+1)+1 cycles with out_ready tied high.
- clear (any state): next state IDLE, acc/ovf/row/lane zeroed, out_valid drops. out_dot and out_ovf are not cleared.
  - clear with a simultaneous accept: clear wins and the row is discarded.
  - clear in OUT: the result is dropped.
- rst mid-operation: immediate return to reset values; no partial result is emitted.

Decomposition:
- Shared package calc_pkg: state encoding, default widths (DATA_W_DEF=8, WEIGHT_W_DEF=8, SUM_W_DEF=21), and a saturating-add function keyed on SIGNED/SUM_W.
- One sub-module conv_dot_mac: combinational multiply plus extend plus add/clamp, producing next_acc and ovf_step. The FSM and registers remain in the top module.

Test Plan:
- Unsigned 3x3, rows [1,2,3],[4,5,6],[7,8,9], all weights 1, out_ready=1 → out_dot=45, out_ovf=0. Accepts at cycles 0/4/8, out_valid at cycle 12 for exactly 1 cycle.
- SIGNED=1, all data −128, all weights −128 → out_dot=147456.
  - SUM_W=16, SAT=1 → out_dot=32767, out_ovf=1.
  - SUM_W=16, SAT=0 → out_dot=16384, out_ovf=1.
- Backpressure: out_ready low for 5 cycles after out_valid → out_dot stable, in_ready=0 throughout. Completes on the first out_ready=1 cycle, then in_ready=1 next cycle.
- acc_keep: window A (data all 1, weights all 2) gives 18. Window B with acc_keep=1 on its first row and the same data gives out_dot=36; with acc_keep=0 it gives 18.
- clear asserted in MAC of row 1 → out_valid never rises for that window. The next full window of all-1 data and weights gives 9, with no residue.
- Change weights after the first row is accepted → result uses the latched kernel. Async rst pulse mid-window → out_dot=0, out_valid=0, in_ready=1 immediately after deassertion.
